// File: rtl/cpu_param_core.sv
// cpu_param_core: small parameterised accumulator/move CPU.
// A program ROM outside the block supplies one instruction word per program
// address. Instructions retire only on "go" cycles, which are produced either
// by a free-running tick divider or, in turbo mode, on every clock.
// The register file holds the I/O and flag registers in its top slots:
//   Reg[NREG-1] flags (bit0 ZERO, bit1 CARRY, bit2 SHFT)
//   Reg[NREG-2] Dout, Reg[NREG-3] GPO, Reg[NREG-4] sampled Din.

module cpu_param_core #(
  parameter int DW      = 8,
  parameter int NREG    = 32,
  parameter int AW      = 8,
  parameter int CNT_MAX = 12500000
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Turbo,
  input  logic            Sample,
  input  logic [DW-1:0]   Din,
  output logic [AW-1:0]   PAddr,
  input  logic [26+AW:0]  PData,
  output logic [DW-1:0]   Dout,
  output logic            Dval,
  output logic [DW-1:0]   GPO
);

  localparam int RW = $clog2(NREG);
  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CW-1:0] CNT_TC    = CW'(CNT_MAX);
  localparam logic [RW-1:0] IDX_FLAGS = RW'(NREG - 1);
  localparam logic [RW-1:0] IDX_DOUT  = RW'(NREG - 2);
  localparam logic [RW-1:0] IDX_GPO   = RW'(NREG - 3);
  localparam logic [RW-1:0] IDX_DIN   = RW'(NREG - 4);

  localparam logic [3:0] GRP_MOV = 4'd0;
  localparam logic [3:0] GRP_JMP = 4'd1;
  localparam logic [3:0] GRP_ACC = 4'd2;

  // Architectural and control state
  logic [DW-1:0] r_regs [NREG];
  logic [AW-1:0] r_ip;
  logic [CW-1:0] r_cnt;
  logic          r_dval;
  logic          r_turbo_s1, r_turbo_s2;
  logic          r_sample_s1, r_sample_s2, r_sample_s3;

  // Instruction fields
  logic [3:0]    w_grp;
  logic [2:0]    w_cmd;
  logic [1:0]    w_t1, w_t2;
  logic [7:0]    w_a1, w_a2;
  logic [AW-1:0] w_addr;

  // Operand and execution signals
  logic [RW-1:0] w_a1_idx, w_a2_idx;
  logic [DW-1:0] w_reg_a1, w_reg_a2;
  logic [DW-1:0] w_ind_a1, w_ind_a2;
  logic [DW-1:0] w_val1, w_val2;
  logic [RW-1:0] w_dst_idx;
  logic          w_dst_ok;
  logic [DW:0]   w_sum, w_diff;
  logic [DW-1:0] w_flags_cur, w_flags_next;
  logic          w_go;
  logic          w_sample_rise;
  logic [AW-1:0] w_ip_inc, w_ip_next;
  logic          w_wr_en;
  logic [DW-1:0] w_wr_data;
  logic [2:0]    w_flag_en;
  logic [2:0]    w_flag_val;
  logic          w_jmp_taken;

  assign w_grp  = PData[26+AW:23+AW];
  assign w_cmd  = PData[22+AW:20+AW];
  assign w_t1   = PData[19+AW:18+AW];
  assign w_a1   = PData[17+AW:10+AW];
  assign w_t2   = PData[9+AW:8+AW];
  assign w_a2   = PData[7+AW:AW];
  assign w_addr = PData[AW-1:0];

  // Operand addresses wrap modulo NREG; indirect pointers use the low bits
  // of the pointer register for the same reason.
  assign w_a1_idx = w_a1[RW-1:0];
  assign w_a2_idx = w_a2[RW-1:0];
  assign w_reg_a1 = r_regs[w_a1_idx];
  assign w_reg_a2 = r_regs[w_a2_idx];
  assign w_ind_a1 = r_regs[w_reg_a1[RW-1:0]];
  assign w_ind_a2 = r_regs[w_reg_a2[RW-1:0]];

  assign w_flags_cur   = r_regs[IDX_FLAGS];
  assign w_sample_rise = r_sample_s2 & ~r_sample_s3;
  assign w_go          = ~Reset & ((r_cnt == CNT_TC) | r_turbo_s2);
  assign w_ip_inc      = r_ip + AW'(1);

  assign w_sum  = {1'b0, w_val2} + {1'b0, w_val1};
  assign w_diff = {1'b0, w_val2} - {1'b0, w_val1};

  // Resolve the first operand value from its addressing type
  always_comb begin
    case (w_t1)
      2'b01:   w_val1 = w_reg_a1;
      2'b10:   w_val1 = w_ind_a1;
      default: w_val1 = DW'(w_a1);
    endcase
  end

  // Resolve the second operand value and the destination register
  always_comb begin
    w_dst_ok  = 1'b0;
    w_dst_idx = w_a2_idx;
    case (w_t2)
      2'b01: begin
        w_val2   = w_reg_a2;
        w_dst_ok = 1'b1;
      end
      2'b10: begin
        w_val2    = w_ind_a2;
        w_dst_ok  = 1'b1;
        w_dst_idx = w_reg_a2[RW-1:0];
      end
      default: w_val2 = DW'(w_a2);
    endcase
  end

  // Decode and execute the current instruction into write/flag/IP intents
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    w_flag_en   = 3'b000;
    w_flag_val  = 3'b000;
    w_jmp_taken = 1'b0;
    w_ip_next   = w_ip_inc;
    case (w_grp)
      GRP_MOV: begin
        w_wr_en = w_dst_ok;
        case (w_cmd)
          3'd1: begin
            w_wr_data     = {w_val1[DW-2:0], 1'b0};
            w_flag_en[2]  = 1'b1;
            w_flag_val[2] = w_val1[DW-1];
          end
          3'd2: begin
            w_wr_data     = {1'b0, w_val1[DW-1:1]};
            w_flag_en[2]  = 1'b1;
            w_flag_val[2] = w_val1[0];
          end
          default: w_wr_data = w_val1;
        endcase
      end
      GRP_ACC: begin
        // Logic ops clear CARRY; undefined ops change nothing at all.
        if (w_cmd <= 3'd4) begin
          w_wr_en      = w_dst_ok;
          w_flag_en    = 3'b011;
          case (w_cmd)
            3'd0: begin
              w_wr_data     = w_sum[DW-1:0];
              w_flag_val[1] = w_sum[DW];
            end
            3'd1: begin
              w_wr_data     = w_diff[DW-1:0];
              w_flag_val[1] = w_diff[DW];
            end
            3'd2:    w_wr_data = w_val2 & w_val1;
            3'd3:    w_wr_data = w_val2 | w_val1;
            default: w_wr_data = w_val2 ^ w_val1;
          endcase
          w_flag_val[0] = (w_wr_data == '0);
        end
      end
      GRP_JMP: begin
        case (w_cmd)
          3'd0:    w_jmp_taken = 1'b1;
          3'd1:    w_jmp_taken = w_flags_cur[0];
          3'd2:    w_jmp_taken = w_flags_cur[1];
          3'd3:    w_jmp_taken = ~w_flags_cur[0];
          default: w_jmp_taken = 1'b0;
        endcase
        if (w_jmp_taken) w_ip_next = w_addr;
      end
      default: ;
    endcase
  end

  // Merge the hardware flag update into the flag register, leaving
  // software-owned upper bits untouched
  always_comb begin
    w_flags_next = w_flags_cur;
    for (int b = 0; b < 3; b++) begin
      if (w_flag_en[b]) w_flags_next[b] = w_flag_val[b];
    end
  end

  // Two-flop synchronisers for the asynchronous control inputs, plus a
  // third Sample stage for rising-edge detection
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_turbo_s1  <= 1'b0;
      r_turbo_s2  <= 1'b0;
      r_sample_s1 <= 1'b0;
      r_sample_s2 <= 1'b0;
      r_sample_s3 <= 1'b0;
    end else begin
      r_turbo_s1  <= Turbo;
      r_turbo_s2  <= r_turbo_s1;
      r_sample_s1 <= Sample;
      r_sample_s2 <= r_sample_s1;
      r_sample_s3 <= r_sample_s2;
    end
  end

  // Execution-tick divider, wraps after the terminal count
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_TC) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Instruction pointer advances only on go cycles
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ip <= '0;
    end else if (w_go) begin
      r_ip <= w_ip_next;
    end
  end

  // Register file; later assignments win, so an explicit write to the flag
  // register beats the flag update and a Sample capture beats everything
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_go && (w_flag_en != 3'b000)) r_regs[IDX_FLAGS] <= w_flags_next;
      if (w_go && w_wr_en) r_regs[w_dst_idx] <= w_wr_data;
      if (w_sample_rise) r_regs[IDX_DIN] <= Din;
    end
  end

  // One-cycle strobe accompanying every write to the Dout register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_dval <= 1'b0;
    end else begin
      r_dval <= w_go && w_wr_en && (w_dst_idx == IDX_DOUT);
    end
  end

  assign PAddr = r_ip;
  assign Dout  = r_regs[IDX_DOUT];
  assign GPO   = r_regs[IDX_GPO];
  assign Dval  = r_dval;

endmodule

// File: tb/tb_cpu_param_core.sv
// tb_cpu_param_core: directed programs for cpu_param_core (DW=8, NREG=32,
// AW=8, CNT_MAX=3). Programs live in a bench-side ROM; results are observed
// through PAddr, GPO (R29), Dout (R30) and the Dval strobe.

module tb_cpu_param_core;

  localparam int DW = 8;
  localparam int NREG = 32;
  localparam int AW = 8;
  localparam int CNT_MAX = 3;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Turbo = 1'b0;
  logic          Sample = 1'b0;
  logic [DW-1:0] Din = '0;
  logic [AW-1:0] PAddr;
  logic [26+AW:0] PData;
  logic [DW-1:0] Dout;
  logic          Dval;
  logic [DW-1:0] GPO;

  logic [26+AW:0] rom [256];
  int n_tests = 0;
  int n_fail = 0;
  int dval_cnt = 0;

  cpu_param_core #(.DW(DW), .NREG(NREG), .AW(AW), .CNT_MAX(CNT_MAX)) dut (
    .Clock(Clock), .Reset(Reset), .Turbo(Turbo), .Sample(Sample), .Din(Din),
    .PAddr(PAddr), .PData(PData), .Dout(Dout), .Dval(Dval), .GPO(GPO)
  );

  always #5 Clock = ~Clock;

  assign PData = rom[PAddr];

  always @(negedge Clock) begin
    if (Reset) dval_cnt = 0;
    else if (Dval) dval_cnt = dval_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] enc(input logic [3:0] g, input logic [2:0] c,
                                      input logic [1:0] t1, input logic [7:0] a1,
                                      input logic [1:0] t2, input logic [7:0] a2,
                                      input logic [7:0] ad);
    return {g, c, t1, a1, t2, a2, ad};
  endfunction

  function automatic logic [34:0] mov_imm(input logic [7:0] v, input logic [7:0] r);
    return enc(4'd0, 3'd0, 2'b00, v, 2'b01, r, 8'h00);
  endfunction

  function automatic logic [34:0] mov_rr(input logic [7:0] s, input logic [7:0] d);
    return enc(4'd0, 3'd0, 2'b01, s, 2'b01, d, 8'h00);
  endfunction

  function automatic logic [34:0] jmp(input logic [2:0] c, input logic [7:0] ad);
    return enc(4'd1, c, 2'b00, 8'h00, 2'b00, 8'h00, ad);
  endfunction

  function automatic logic [34:0] acc(input logic [2:0] c, input logic [7:0] r, input logic [7:0] imm);
    return enc(4'd2, c, 2'b00, imm, 2'b01, r, 8'h00);
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = enc(4'hF, 3'd0, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic do_reset(input logic turbo);
    @(negedge Clock);
    Reset = 1'b1;
    Turbo = turbo;
    Sample = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Wait (bounded) for the program to reach its halt address, then settle
  task automatic run_to(input logic [7:0] tgt, input string tag);
    int n;
    n = 0;
    while (PAddr !== tgt && n < 300) begin
      @(negedge Clock);
      n++;
    end
    check({tag, "_ip"}, 32'(PAddr), 32'(tgt));
    repeat (3) @(negedge Clock);
  endtask

  initial begin
    // Reset state and divided-tick pacing with Turbo low
    clear_rom();
    repeat (3) @(negedge Clock);
    check("rst_ip", 32'(PAddr), 0);
    check("rst_dout", 32'(Dout), 0);
    check("rst_gpo", 32'(GPO), 0);
    check("rst_dval", 32'(Dval), 0);
    Reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clock);
      #1;
      check($sformatf("tick_ip_%0d", k), 32'(PAddr), 32'(k / 4));
    end
    rom[2] = mov_imm(8'h77, 8'd30);
    for (int k = 9; k <= 11; k++) begin
      @(posedge Clock);
      #1;
      check($sformatf("tick_hold_%0d", k), 32'(PAddr), 2);
    end
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("midrst_ip", 32'(PAddr), 0);
    check("midrst_dval", 32'(Dval), 0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge Clock);
      #1;
      check($sformatf("resume_ip_%0d", k), 32'(PAddr), 32'(k / 4));
    end
    check("midrst_dout", 32'(Dout), 0);

    // MOV #5 -> R0; ADD #3 -> R0
    clear_rom();
    rom[0] = mov_imm(8'd5, 8'd0);
    rom[1] = acc(3'd0, 8'd0, 8'd3);
    rom[2] = mov_rr(8'd0, 8'd29);
    rom[3] = mov_rr(8'd31, 8'd30);
    rom[4] = jmp(3'd0, 8'd4);
    do_reset(1'b1);
    run_to(8'd4, "add");
    check("add_r0", 32'(GPO), 8);
    check("add_flags", 32'(Dout), 0);
    check("add_dval", 32'(dval_cnt), 1);

    // 0xFF + 1 wraps to zero with carry, then JMP-if-ZERO
    clear_rom();
    rom[0] = mov_imm(8'hFF, 8'd0);
    rom[1] = acc(3'd0, 8'd0, 8'd1);
    rom[2] = jmp(3'd1, 8'h40);
    rom[3] = mov_imm(8'h11, 8'd29);
    rom[8'h40] = mov_rr(8'd31, 8'd29);
    rom[8'h41] = mov_rr(8'd0, 8'd30);
    rom[8'h42] = jmp(3'd0, 8'h42);
    do_reset(1'b1);
    run_to(8'h42, "carry");
    check("carry_flags", 32'(GPO), 32'h03);
    check("carry_r0", 32'(Dout), 0);
    check("carry_dval", 32'(dval_cnt), 1);

    // SHL then SHR through the shift flag
    clear_rom();
    rom[0] = mov_imm(8'h81, 8'd1);
    rom[1] = enc(4'd0, 3'd1, 2'b01, 8'd1, 2'b01, 8'd1, 8'h00);
    rom[2] = mov_rr(8'd1, 8'd29);
    rom[3] = mov_rr(8'd31, 8'd30);
    rom[4] = jmp(3'd0, 8'd4);
    do_reset(1'b1);
    run_to(8'd4, "shl");
    check("shl_r1", 32'(GPO), 32'h02);
    check("shl_flags", 32'(Dout), 32'h04);
    rom[4] = enc(4'd0, 3'd2, 2'b01, 8'd1, 2'b01, 8'd1, 8'h00);
    rom[5] = mov_rr(8'd1, 8'd29);
    rom[6] = mov_rr(8'd31, 8'd30);
    rom[7] = jmp(3'd0, 8'd7);
    run_to(8'd7, "shr");
    check("shr_r1", 32'(GPO), 32'h01);
    check("shr_flags", 32'(Dout), 32'h00);
    check("shr_dval", 32'(dval_cnt), 2);

    // Indirect destination reaching the Dout register
    clear_rom();
    rom[0] = mov_imm(8'd30, 8'd2);
    rom[1] = enc(4'd0, 3'd0, 2'b00, 8'hA5, 2'b10, 8'd2, 8'h00);
    rom[2] = jmp(3'd0, 8'd2);
    do_reset(1'b1);
    run_to(8'd2, "ind");
    check("ind_dout", 32'(Dout), 32'hA5);
    check("ind_dval", 32'(dval_cnt), 1);

    // Sample capture colliding with an instruction write to R28
    clear_rom();
    rom[0] = jmp(3'd0, 8'd0);
    do_reset(1'b1);
    repeat (5) @(negedge Clock);
    Din = 8'h3C;
    Sample = 1'b1;
    repeat (2) @(negedge Clock);
    rom[0] = mov_imm(8'h00, 8'd28);
    rom[1] = mov_rr(8'd28, 8'd29);
    rom[2] = jmp(3'd0, 8'd2);
    run_to(8'd2, "smp");
    check("smp_r28", 32'(GPO), 32'h3C);
    Sample = 1'b0;

    // SUB borrow, logic ops clearing CARRY, XOR to zero
    clear_rom();
    rom[0]  = mov_imm(8'h0F, 8'd3);
    rom[1]  = acc(3'd1, 8'd3, 8'h10);
    rom[2]  = jmp(3'd2, 8'd5);
    rom[3]  = mov_imm(8'hEE, 8'd29);
    rom[4]  = jmp(3'd0, 8'd4);
    rom[5]  = acc(3'd2, 8'd3, 8'h3C);
    rom[6]  = acc(3'd3, 8'd3, 8'h41);
    rom[7]  = acc(3'd4, 8'd3, 8'hFF);
    rom[8]  = jmp(3'd2, 8'd3);
    rom[9]  = mov_rr(8'd3, 8'd29);
    rom[10] = acc(3'd4, 8'd3, 8'h82);
    rom[11] = mov_rr(8'd31, 8'd30);
    rom[12] = jmp(3'd0, 8'd12);
    do_reset(1'b1);
    run_to(8'd12, "logic");
    check("logic_r3", 32'(GPO), 32'h82);
    check("logic_flags", 32'(Dout), 32'h01);

    // Explicit write to the flag register overrides the flag update
    clear_rom();
    rom[0] = mov_imm(8'hF0, 8'd31);
    rom[1] = acc(3'd0, 8'd31, 8'h0F);
    rom[2] = mov_rr(8'd31, 8'd29);
    rom[3] = jmp(3'd1, 8'd6);
    rom[4] = mov_imm(8'd1, 8'd30);
    rom[5] = jmp(3'd0, 8'd5);
    rom[6] = mov_imm(8'd2, 8'd30);
    rom[7] = jmp(3'd0, 8'd7);
    do_reset(1'b1);
    run_to(8'd7, "fwr");
    check("fwr_r31", 32'(GPO), 32'hFF);
    check("fwr_path", 32'(Dout), 32'h02);

    // Indirect source with address wrap modulo NREG, type-11 immediate
    clear_rom();
    rom[0] = mov_imm(8'd7, 8'd5);
    rom[1] = mov_imm(8'h99, 8'd7);
    rom[2] = enc(4'd0, 3'd0, 2'b10, 8'd37, 2'b01, 8'd29, 8'h00);
    rom[3] = enc(4'd0, 3'd0, 2'b11, 8'h42, 2'b01, 8'd30, 8'h00);
    rom[4] = jmp(3'd0, 8'd4);
    do_reset(1'b1);
    run_to(8'd4, "src");
    check("src_ind", 32'(GPO), 32'h99);
    check("src_imm", 32'(Dout), 32'h42);

    // IP wrap from 0xFF to 0x00; no-destination ADD sets ZERO only
    clear_rom();
    rom[0]     = jmp(3'd3, 8'hFE);
    rom[1]     = mov_imm(8'h5A, 8'd29);
    rom[2]     = jmp(3'd0, 8'd2);
    rom[8'hFE] = enc(4'd2, 3'd0, 2'b00, 8'h00, 2'b00, 8'h00, 8'h00);
    do_reset(1'b1);
    run_to(8'd2, "wrap");
    check("wrap_gpo", 32'(GPO), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
